dac_sample_packer: RTL

DAC_SAMPLE_PACKER -- requirements
Module: dac_sample_packer

---
 rtl/phaser_pkg.sv | 21 ++
 rtl/dac_ovf_counter.sv | 44 ++++
 rtl/dac_sample_packer.sv | 105 ++++++++++
 3 files changed

// File: rtl/phaser_pkg.sv
// ============================================================================
// Module  : phaser_pkg
// Purpose : Shared packer state encoding and lane/word width constants.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package phaser_pkg;

  localparam int LANE_W = 16;
  localparam int FIFO_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_WAIT_HI = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dac_ovf_counter.sv
// ============================================================================
// Module  : dac_ovf_counter
// Purpose : Saturating dropped-word counter with sticky flag and clear.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dac_ovf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_flag
);

  logic [CNT_W-1:0] r_count;
  logic             r_flag;

  // A clear coinciding with a drop is applied first, so that drop counts as 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else if (i_inc) begin
      if (i_clr)
        r_count <= CNT_W'(1);
      else if (r_count != {CNT_W{1'b1}})
        r_count <= r_count + 1'b1;
      r_flag <= 1'b1;
    end else if (i_clr) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_flag  = r_flag;

endmodule

`default_nettype wire

// File: rtl/dac_sample_packer.sv
// ============================================================================
// Module  : dac_sample_packer
// Purpose : Packs pairs of DDS samples into 32-bit DAC FIFO words.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dac_sample_packer
  import phaser_pkg::*;
#(
  parameter int SAMPLE_W  = 12,
  parameter int CNT_W     = 16,
  parameter int MSB_ALIGN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                dacfifo_full,
  input  logic                ovf_clear,
  output logic                dacfifo_write,
  output logic [FIFO_W-1:0]   dacfifo_writedata,
  output logic [CNT_W-1:0]    ovf_count,
  output logic                ovf_flag
);

  localparam int c_PAD = LANE_W - SAMPLE_W;

  state_t              r_state;
  logic [LANE_W-1:0]   r_lo;
  logic                r_write;
  logic [FIFO_W-1:0]   r_wdata;
  logic [LANE_W-1:0]   w_sext;
  logic [LANE_W-1:0]   w_conv;
  logic                w_complete;
  logic                w_drop;

  assign w_sext = LANE_W'($signed(sample_data));

  generate
    if (MSB_ALIGN != 0) begin : g_msb_align
      // Shifting the sign-extended value discards exactly the extension bits.
      assign w_conv = w_sext << c_PAD;
    end else begin : g_sign_ext
      assign w_conv = w_sext;
    end
  endgenerate

  assign w_complete = enable && sample_valid && (r_state == ST_WAIT_HI);
  assign w_drop     = w_complete && dacfifo_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lo    <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (sample_valid) begin
            r_lo    <= w_conv;
            r_state <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (sample_valid) begin
            if (!dacfifo_full) begin
              r_write <= 1'b1;
              r_wdata <= {w_conv, r_lo};
            end
            r_state <= ST_WAIT_LO;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dac_ovf_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (ovf_clear),
    .i_inc   (w_drop),
    .o_count (ovf_count),
    .o_flag  (ovf_flag)
  );

  assign dacfifo_write     = r_write;
  assign dacfifo_writedata = r_wdata;

endmodule

`default_nettype wire
